// File: rtl/lsu_bus_adapter_if.sv
// Core-side request/response and bus-side valid/ready signals of the LSU bus adapter.
// "master" is the adapter's view; "slave" is the view of the core/bus environment.
interface lsu_bus_adapter_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int NB = XLEN / 8;

  logic                  io_req_valid;
  logic                  io_req_store;
  logic [1:0]            io_req_size;
  logic                  io_req_signed;
  logic [ADDR_WIDTH-1:0] io_req_addr;
  logic [XLEN-1:0]       io_req_wdata;
  logic                  io_stall;
  logic                  io_resp_valid;
  logic [XLEN-1:0]       io_resp_rdata;
  logic                  io_fault;
  logic [1:0]            io_fault_cause;

  logic                  io_bus_req_valid;
  logic                  io_bus_req_ready;
  logic [ADDR_WIDTH-1:0] io_bus_addr;
  logic                  io_bus_we;
  logic [NB-1:0]         io_bus_mask;
  logic [XLEN-1:0]       io_bus_wdata;
  logic                  io_bus_resp_valid;
  logic                  io_bus_resp_err;
  logic [XLEN-1:0]       io_bus_rdata;

  modport master (
    input  io_req_valid, io_req_store, io_req_size, io_req_signed, io_req_addr, io_req_wdata,
    output io_stall, io_resp_valid, io_resp_rdata, io_fault, io_fault_cause,
    output io_bus_req_valid, io_bus_addr, io_bus_we, io_bus_mask, io_bus_wdata,
    input  io_bus_req_ready, io_bus_resp_valid, io_bus_resp_err, io_bus_rdata
  );

  modport slave (
    output io_req_valid, io_req_store, io_req_size, io_req_signed, io_req_addr, io_req_wdata,
    input  io_stall, io_resp_valid, io_resp_rdata, io_fault, io_fault_cause,
    input  io_bus_req_valid, io_bus_addr, io_bus_we, io_bus_mask, io_bus_wdata,
    output io_bus_req_ready, io_bus_resp_valid, io_bus_resp_err, io_bus_rdata
  );
endinterface

// File: rtl/lsu_bus_adapter.sv
// Load/store unit between the core memory stage and a variable-latency valid/ready bus.
// Builds byte lanes/masks, aligns and extends load data, stalls the core, reports faults.
module lsu_bus_adapter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic              clk,
  input logic              rst,
  lsu_bus_adapter_if.master io
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state, state_nxt;
  logic [15:0]           cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q, sgn_q;
  logic [1:0]            size_q;
  logic [LW-1:0]         lane_q;
  logic [NB-1:0]         mask_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  fault_q;
  logic [1:0]            cause_q;
  logic [XLEN-1:0]       rdata_q;

  logic                  misaligned, latch, timeout_hit;
  logic [LW-1:0]         lane;
  logic [NB-1:0]         mask_base, mask_d;
  logic [2:0]            bytes_m1;
  logic [XLEN-1:0]       wdata_d, shifted, load_d;
  logic                  fin_fault;
  logic [1:0]            fin_cause;
  logic [XLEN-1:0]       fin_rdata;
  int unsigned           src;

  assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

  // Decode the incoming request: alignment, lane, byte mask and replicated store data
  always_comb begin
    lane = io.io_req_addr[LW-1:0];
    case (io.io_req_size)
      2'd0: begin misaligned = 1'b0; mask_base = NB'(1); bytes_m1 = 3'd0; end
      2'd1: begin misaligned = io.io_req_addr[0]; mask_base = NB'(3); bytes_m1 = 3'd1; end
      2'd2: begin misaligned = |io.io_req_addr[1:0]; mask_base = NB'(15); bytes_m1 = 3'd3; end
      default: begin
        misaligned = (XLEN == 32) || (|io.io_req_addr[2:0]);
        mask_base  = NB'(255);
        bytes_m1   = 3'd7;
      end
    endcase
    mask_d  = mask_base << lane;
    wdata_d = '0;
    src     = 0;
    for (int unsigned i = 0; i < NB; i++) begin
      // Wrapping the source byte index repeats the low 2^size bytes on every lane
      src = i & 32'(bytes_m1) & 32'(NB - 1);
      wdata_d[8*i +: 8] = io.io_req_wdata[8*src +: 8];
    end
  end

  // Align the bus read data to the addressed lane and extend to XLEN
  always_comb begin
    shifted = io.io_bus_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    load_d = sgn_q ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
      2'd1:    load_d = sgn_q ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
      2'd2:    load_d = sgn_q ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
      default: load_d = shifted;
    endcase
  end

  // State register; reset returns to IDLE from anywhere, mid-transaction included
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and the completion values loaded on entry to DONE
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    fin_fault = 1'b0;
    fin_cause = 2'b00;
    fin_rdata = '0;
    case (state)
      IDLE: if (io.io_req_valid) begin
        if (misaligned) begin
          state_nxt = DONE;
          fin_fault = 1'b1;
          fin_cause = 2'b01;
        end else begin
          state_nxt = REQ;
          latch     = 1'b1;
        end
      end
      REQ: begin
        if (timeout_hit) begin
          state_nxt = DONE;
          fin_fault = 1'b1;
          fin_cause = 2'b11;
        end else if (io.io_bus_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response in the final counted cycle still wins over the timeout
        if (io.io_bus_resp_valid) begin
          state_nxt = DONE;
          if (io.io_bus_resp_err) begin
            fin_fault = 1'b1;
            fin_cause = 2'b10;
          end else if (!we_q) begin
            fin_rdata = load_d;
          end
        end else if (timeout_hit) begin
          state_nxt = DONE;
          fin_fault = 1'b1;
          fin_cause = 2'b11;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timeout counter: counts cycles spent in REQ and WAIT, zero elsewhere
  always_ff @(posedge clk) begin
    if (!rst)                             cnt <= '0;
    else if (state == REQ || state == WAIT) cnt <= cnt + 16'd1;
    else                                  cnt <= '0;
  end

  // Latched request and completion registers; completion values live only in DONE
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      rdata_q <= '0;
    end else begin
      if (latch) begin
        addr_q  <= io.io_req_addr & ~ADDR_WIDTH'(NB - 1);
        we_q    <= io.io_req_store;
        sgn_q   <= io.io_req_signed;
        size_q  <= io.io_req_size;
        lane_q  <= lane;
        mask_q  <= mask_d;
        wdata_q <= wdata_d;
      end
      fault_q <= fin_fault;
      cause_q <= fin_cause;
      rdata_q <= fin_rdata;
    end
  end

  assign io.io_stall         = rst & io.io_req_valid & (state != DONE);
  assign io.io_resp_valid    = (state == DONE);
  assign io.io_resp_rdata    = rdata_q;
  assign io.io_fault         = fault_q;
  assign io.io_fault_cause   = cause_q;
  assign io.io_bus_req_valid = (state == REQ);
  assign io.io_bus_addr      = addr_q;
  assign io.io_bus_we        = we_q;
  assign io.io_bus_mask      = mask_q;
  assign io.io_bus_wdata     = wdata_q;
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Scoreboard bench for lsu_bus_adapter: a 32-bit instance (TIMEOUT=8) and a 64-bit instance.
module tb_lsu_bus_adapter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_bus_adapter_if #(.XLEN(32), .ADDR_WIDTH(32)) if32 ();
  lsu_bus_adapter_if #(.XLEN(64), .ADDR_WIDTH(32)) if64 ();

  lsu_bus_adapter #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(8)) u_dut32 (.clk(clk), .rst(rst), .io(if32));
  lsu_bus_adapter #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT(255)) u_dut64 (.clk(clk), .rst(rst), .io(if64));

  // sel=0 drives the 32-bit instance, sel=1 the 64-bit instance
  logic        sel, req_valid, req_store, req_signed, bus_ready, bus_resp_valid, bus_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, bus_rdata;

  assign if32.io_req_valid      = req_valid & ~sel;
  assign if32.io_req_store      = req_store;
  assign if32.io_req_size       = req_size;
  assign if32.io_req_signed     = req_signed;
  assign if32.io_req_addr       = req_addr;
  assign if32.io_req_wdata      = req_wdata[31:0];
  assign if32.io_bus_req_ready  = bus_ready & ~sel;
  assign if32.io_bus_resp_valid = bus_resp_valid & ~sel;
  assign if32.io_bus_resp_err   = bus_err;
  assign if32.io_bus_rdata      = bus_rdata[31:0];

  assign if64.io_req_valid      = req_valid & sel;
  assign if64.io_req_store      = req_store;
  assign if64.io_req_size       = req_size;
  assign if64.io_req_signed     = req_signed;
  assign if64.io_req_addr       = req_addr;
  assign if64.io_req_wdata      = req_wdata;
  assign if64.io_bus_req_ready  = bus_ready & sel;
  assign if64.io_bus_resp_valid = bus_resp_valid & sel;
  assign if64.io_bus_resp_err   = bus_err;
  assign if64.io_bus_rdata      = bus_rdata;

  logic        m_stall, m_breq, m_we, m_resp_valid, m_fault;
  logic [1:0]  m_cause;
  logic [31:0] m_baddr;
  logic [7:0]  m_mask;
  logic [63:0] m_bwdata, m_rdata;

  // Outputs of the currently selected instance
  always_comb begin
    if (sel) begin
      m_stall = if64.io_stall; m_breq = if64.io_bus_req_valid; m_we = if64.io_bus_we;
      m_resp_valid = if64.io_resp_valid; m_fault = if64.io_fault; m_cause = if64.io_fault_cause;
      m_baddr = if64.io_bus_addr; m_mask = if64.io_bus_mask; m_bwdata = if64.io_bus_wdata;
      m_rdata = if64.io_resp_rdata;
    end else begin
      m_stall = if32.io_stall; m_breq = if32.io_bus_req_valid; m_we = if32.io_bus_we;
      m_resp_valid = if32.io_resp_valid; m_fault = if32.io_fault; m_cause = if32.io_fault_cause;
      m_baddr = if32.io_bus_addr; m_mask = {4'h0, if32.io_bus_mask};
      m_bwdata = {32'h0, if32.io_bus_wdata}; m_rdata = {32'h0, if32.io_resp_rdata};
    end
  end

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_resp(input string nm, input logic [63:0] rd, input logic f, input logic [1:0] c);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected response: got rdata 0x%0h fault %0b cause %0b required none", nm, rd, f, c);
    end else begin
      e = q.pop_front();
      chk({nm, "_rdata"}, rd, e.rdata);
      chk({nm, "_fault"}, 64'(f), 64'(e.fault));
      chk({nm, "_cause"}, 64'(c), 64'(e.cause));
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expected response
  always @(negedge clk) begin
    if (if32.io_resp_valid) check_resp("resp32", {32'h0, if32.io_resp_rdata}, if32.io_fault, if32.io_fault_cause);
    if (if64.io_resp_valid) check_resp("resp64", if64.io_resp_rdata, if64.io_fault, if64.io_fault_cause);
  end

  // One core request with a scripted bus: ready after dly REQ cycles, response one cycle after accept
  task automatic txn(input string nm, input logic s, input logic st, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [63:0] wd, input int dly, input logic [63:0] rd,
                     input logic er, input logic [31:0] e_baddr, input logic [7:0] e_mask,
                     input logic [63:0] e_wdata, input int e_req, input logic [63:0] e_rdata,
                     input logic e_fault, input logic [1:0] e_cause, input int e_cyc);
    exp_t e;
    int   stalls, reqc, cyc;
    logic acc, sent, done;
    e.rdata = e_rdata; e.fault = e_fault; e.cause = e_cause;
    q.push_back(e);
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; bus_rdata = rd; bus_err = er;
    stalls = 0; reqc = 0; cyc = 0; acc = 1'b0; sent = 1'b0; done = 1'b0;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      cyc = c;
      if (m_resp_valid) begin
        done = 1'b1;
        req_valid = 1'b0;
        bus_resp_valid = 1'b0;
        bus_ready = 1'b0;
      end else begin
        if (m_stall) stalls++;
        bus_resp_valid = 1'b0;
        if (acc && !sent) begin
          bus_resp_valid = 1'b1;
          sent = 1'b1;
        end
        if (m_breq) begin
          reqc++;
          chk({nm, "_bus_addr"}, 64'(m_baddr), 64'(e_baddr));
          chk({nm, "_bus_mask"}, 64'(m_mask), 64'(e_mask));
          chk({nm, "_bus_we"}, 64'(m_we), 64'(st));
          chk({nm, "_bus_wdata"}, m_bwdata, e_wdata);
          bus_ready = (reqc > dly);
          acc = bus_ready;
        end else begin
          bus_ready = 1'b0;
        end
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no resp_valid in 40 cycles required resp at cycle %0d", nm, e_cyc);
      req_valid = 1'b0;
      bus_ready = 1'b0;
      bus_resp_valid = 1'b0;
    end else begin
      chk({nm, "_resp_cycle"}, 64'(cyc), 64'(e_cyc));
      chk({nm, "_stall_cycles"}, 64'(stalls), 64'(e_cyc));
      chk({nm, "_req_cycles"}, 64'(reqc), 64'(e_req));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_resp_valid = 1'b0; bus_err = 1'b0;
    bus_rdata = '0; rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 req_valid = 1'b1;
    #1;
    chk("rst_stall_forced", 64'(m_stall), 64'h0);
    chk("rst_bus_req_valid", 64'(m_breq), 64'h0);
    chk("rst_resp_valid", 64'(m_resp_valid), 64'h0);
    chk("rst_fault", 64'(m_fault), 64'h0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    //   name   sel st sz sg addr          wdata        dly rdata                  err baddr         mask   bus wdata               req exp rdata              flt cause cyc
    txn("lb",   0, 0, 0, 1, 32'h0000_1003, 64'h0,        0, 64'h80FF_0000,          0, 32'h0000_1000, 8'h08, 64'h0,                  1, 64'hFFFF_FF80,          0, 2'b00, 3);
    txn("sh",   0, 1, 1, 0, 32'h0000_2002, 64'h1234_ABCD, 0, 64'hFFFF_FFFF,         0, 32'h0000_2000, 8'h0C, 64'hABCD_ABCD,          1, 64'h0,                  0, 2'b00, 3);
    txn("lw_mis", 0, 0, 2, 0, 32'h0000_0002, 64'h0,      0, 64'h0,                  0, 32'h0,         8'h00, 64'h0,                  0, 64'h0,                  1, 2'b01, 1);
    txn("lhu",  0, 0, 1, 0, 32'h0000_3002, 64'h0,        0, 64'h8001_1234,          0, 32'h0000_3000, 8'h0C, 64'h0,                  1, 64'h0000_8001,          0, 2'b00, 3);
    txn("lbu",  0, 0, 0, 0, 32'h0000_1001, 64'h0,        0, 64'h1234_5678,          0, 32'h0000_1000, 8'h02, 64'h0,                  1, 64'h56,                 0, 2'b00, 3);
    txn("sb",   0, 1, 0, 0, 32'h0000_5001, 64'hA5,       0, 64'h0,                  0, 32'h0000_5000, 8'h02, 64'hA5A5_A5A5,          1, 64'h0,                  0, 2'b00, 3);
    txn("lw_err", 0, 0, 2, 0, 32'h0000_4000, 64'h0,      5, 64'hDEAD_BEEF,          1, 32'h0000_4000, 8'h0F, 64'h0,                  6, 64'h0,                  1, 2'b10, 8);
    txn("lw",   0, 0, 2, 1, 32'h0000_4004, 64'h0,        0, 64'hDEAD_BEEF,          0, 32'h0000_4004, 8'h0F, 64'h0,                  1, 64'hDEAD_BEEF,          0, 2'b00, 3);
    txn("ld32", 0, 0, 3, 0, 32'h0000_0008, 64'h0,        0, 64'h0,                  0, 32'h0,         8'h00, 64'h0,                  0, 64'h0,                  1, 2'b01, 1);
    txn("tmo",  0, 0, 2, 0, 32'h0000_7000, 64'h0,      100, 64'h0,                  0, 32'h0000_7000, 8'h0F, 64'h0,                  8, 64'h0,                  1, 2'b11, 9);

    // Late bus response after the timeout must not produce a completion
    @(negedge clk);
    #1 bus_resp_valid = 1'b1; bus_rdata = 64'h55;
    @(negedge clk);
    #1 bus_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_resp_valid", 64'(m_resp_valid), 64'h0);
      chk("late_bus_req_valid", 64'(m_breq), 64'h0);
      @(negedge clk);
      #1;
    end

    // Reset asserted while waiting for the bus response
    sel = 1'b0; req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0000_6000; req_wdata = '0;
    @(negedge clk);
    #1 chk("rw_bus_req_valid", 64'(m_breq), 64'h1);
    bus_ready = 1'b1;
    @(negedge clk);
    #1 bus_ready = 1'b0;
    chk("rw_wait_stall", 64'(m_stall), 64'h1);
    rst = 1'b0;
    #1 chk("rw_stall_in_rst", 64'(m_stall), 64'h0);
    @(negedge clk);
    #1;
    chk("rw_resp_valid", 64'(m_resp_valid), 64'h0);
    chk("rw_bus_req_valid0", 64'(m_breq), 64'h0);
    chk("rw_fault", 64'(m_fault), 64'h0);
    chk("rw_cause", 64'(m_cause), 64'h0);
    chk("rw_rdata", m_rdata, 64'h0);
    chk("rw_bus_addr", 64'(m_baddr), 64'h0);
    chk("rw_bus_mask", 64'(m_mask), 64'h0);
    chk("rw_bus_we", 64'(m_we), 64'h0);
    chk("rw_bus_wdata", m_bwdata, 64'h0);
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 chk("rw_no_resp", 64'(m_resp_valid), 64'h0);
    end

    txn("lw_after_rst", 0, 0, 2, 0, 32'h0000_6000, 64'h0, 0, 64'h0BAD_F00D,      0, 32'h0000_6000, 8'h0F, 64'h0,                  1, 64'h0BAD_F00D,          0, 2'b00, 3);
    txn("ld64", 1, 0, 3, 0, 32'h0000_0008, 64'h0,        0, 64'h0123_4567_89AB_CDEF, 0, 32'h0000_0008, 8'hFF, 64'h0,               1, 64'h0123_4567_89AB_CDEF, 0, 2'b00, 3);
    txn("lw64", 1, 0, 2, 1, 32'h0000_0014, 64'h0,        0, 64'h8765_4321_0000_0000, 0, 32'h0000_0010, 8'hF0, 64'h0,               1, 64'hFFFF_FFFF_8765_4321, 0, 2'b00, 3);
    txn("sh64", 1, 1, 1, 0, 32'h0000_001A, 64'hBEEF,     0, 64'h0,                  0, 32'h0000_0018, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF, 1, 64'h0,                0, 2'b00, 3);
    txn("ld64_mis", 1, 0, 3, 0, 32'h0000_0004, 64'h0,    0, 64'h0,                  0, 32'h0,         8'h00, 64'h0,                  0, 64'h0,                  1, 2'b01, 1);

    repeat (3) @(negedge clk);
    chk("pending_responses", 64'(q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
